// File: rtl/led_chaser_pwm.sv
// LED chaser: prescaled step sequencer (chase up/down, bounce, fill)
// with a free-running PWM brightness gate on every LED.
// Ports: clk, nrst (async active-low), enable, mode[1:0], duty,
//        led[N_LEDS] (registered), pos (sequencer position), step (advance pulse).
module led_chaser_pwm #(
  parameter int N_LEDS   = 6,
  parameter int DIV_MAX  = 1000000,
  parameter int PWM_BITS = 8,
  localparam int PW = (N_LEDS < 2) ? 1 : $clog2(N_LEDS),
  localparam int CW = (DIV_MAX < 2) ? 1 : $clog2(DIV_MAX + 1)
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] duty,
  output logic [N_LEDS-1:0]   led,
  output logic [PW-1:0]       pos,
  output logic                step
);

  typedef enum logic [1:0] {
    M_UP   = 2'd0,
    M_DN   = 2'd1,
    M_BNC  = 2'd2,
    M_FILL = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  localparam logic [PW-1:0] LAST    = PW'(N_LEDS - 1);
  localparam logic [CW-1:0] DIV_TOP = CW'(DIV_MAX);

  logic [CW-1:0]       clkdiv_q, clkdiv_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PW-1:0]       pos_q, pos_d;
  logic [N_LEDS-1:0]   led_q, led_d;
  logic [N_LEDS-1:0]   pattern;
  logic                step_q, step_d;
  logic                active_q, active_d;
  dir_e                dir_q, dir_d, eff_dir;
  mode_e               mode_q, mode_d, mode_in;

  assign mode_in = mode_e'(mode);

  // Prescaler and step pulse; both frozen while enable is low.
  always_comb begin
    clkdiv_d = clkdiv_q;
    step_d   = 1'b0;
    if (enable) begin
      step_d   = (clkdiv_q == DIV_TOP);
      clkdiv_d = step_d ? '0 : clkdiv_q + CW'(1);
    end
  end

  // Sequencer: mode is sampled only on a step; a mode change
  // forces dir up before the move is applied.
  always_comb begin
    pos_d    = pos_q;
    dir_d    = dir_q;
    active_d = active_q;
    mode_d   = mode_q;
    eff_dir  = dir_q;
    if (step_q) begin
      mode_d = mode_in;
      if (mode_in != mode_q) eff_dir = DIR_UP;
      dir_d = eff_dir;
      if (!active_q) begin
        // first step only lights LED0
        active_d = 1'b1;
      end else begin
        unique case (mode_in)
          M_UP, M_FILL: pos_d = (pos_q == LAST) ? '0 : pos_q + PW'(1);
          M_DN:         pos_d = (pos_q == '0) ? LAST : pos_q - PW'(1);
          M_BNC: begin
            if (eff_dir == DIR_UP) begin
              if (pos_q == LAST) begin
                dir_d = DIR_DN;
                pos_d = LAST - PW'(1);
              end else begin
                pos_d = pos_q + PW'(1);
              end
            end else begin
              if (pos_q == '0) begin
                dir_d = DIR_UP;
                pos_d = PW'(1);
              end else begin
                pos_d = pos_q - PW'(1);
              end
            end
          end
          default: pos_d = pos_q;
        endcase
      end
    end
  end

  // Pattern uses the mode latched on the last step.
  always_comb begin
    pattern = '0;
    if (active_q) begin
      for (int i = 0; i < N_LEDS; i++) begin
        if (mode_q == M_FILL) pattern[i] = (i <= int'(pos_q));
        else                  pattern[i] = (i == int'(pos_q));
      end
    end
  end

  always_comb begin
    pwm_d = pwm_q + PWM_BITS'(1);
    led_d = pattern & {N_LEDS{pwm_q < duty}};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      clkdiv_q <= '0;
      pwm_q    <= '0;
      pos_q    <= '0;
      led_q    <= '0;
      step_q   <= 1'b0;
      active_q <= 1'b0;
      dir_q    <= DIR_UP;
      mode_q   <= M_UP;
    end else begin
      clkdiv_q <= clkdiv_d;
      pwm_q    <= pwm_d;
      pos_q    <= pos_d;
      led_q    <= led_d;
      step_q   <= step_d;
      active_q <= active_d;
      dir_q    <= dir_d;
      mode_q   <= mode_d;
    end
  end

  assign led  = led_q;
  assign pos  = pos_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_chaser_pwm.sv
// Self-checking bench for led_chaser_pwm (N_LEDS=4, DIV_MAX=3, PWM_BITS=2)
// with a behavioural reference model and randomized stimulus.
module tb_led_chaser_pwm;

  localparam int N = 4;
  localparam int D = 3;
  localparam int B = 2;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         enable = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [B-1:0] duty = '0;
  logic [N-1:0] led;
  logic [1:0]   pos;
  logic         step;

  int n_checks = 0;
  int n_fail = 0;

  led_chaser_pwm #(.N_LEDS(N), .DIV_MAX(D), .PWM_BITS(B)) dut (
    .clk(clk), .nrst(nrst), .enable(enable), .mode(mode),
    .duty(duty), .led(led), .pos(pos), .step(step)
  );

  always #5 clk = ~clk;

  int       m_div, m_pos, m_dir, m_prev, m_pwm;
  bit       m_step, m_active;
  logic [N-1:0] m_led;

  function automatic logic [N-1:0] m_pattern();
    if (!m_active) return '0;
    if (m_prev == 3) return N'((1 << (m_pos + 1)) - 1);
    return N'(1 << m_pos);
  endfunction

  task automatic model_reset();
    m_div = 0; m_pos = 0; m_dir = 1; m_prev = 0; m_pwm = 0;
    m_step = 0; m_active = 0; m_led = '0;
  endtask

  task automatic cycle();
    logic [N-1:0] led_n;
    int div_n, pos_n, dir_n, prev_n, pwm_n;
    bit step_n, act_n;
    led_n  = m_pattern() & ((m_pwm < int'(duty)) ? {N{1'b1}} : {N{1'b0}});
    pwm_n  = (m_pwm + 1) % (1 << B);
    step_n = enable && (m_div == D);
    div_n  = enable ? ((m_div == D) ? 0 : m_div + 1) : m_div;
    pos_n = m_pos; dir_n = m_dir; prev_n = m_prev; act_n = m_active;
    if (m_step) begin
      dir_n  = (int'(mode) != m_prev) ? 1 : m_dir;
      prev_n = int'(mode);
      if (!m_active) act_n = 1;
      else begin
        case (int'(mode))
          0, 3: pos_n = (m_pos + 1) % N;
          1:    pos_n = (m_pos + N - 1) % N;
          default: begin
            if (dir_n == 1) begin
              if (m_pos == N - 1) begin dir_n = -1; pos_n = N - 2; end
              else pos_n = m_pos + 1;
            end else begin
              if (m_pos == 0) begin dir_n = 1; pos_n = 1; end
              else pos_n = m_pos - 1;
            end
          end
        endcase
      end
    end
    @(posedge clk);
    m_led = led_n; m_pwm = pwm_n; m_step = step_n; m_div = div_n;
    m_pos = pos_n; m_dir = dir_n; m_prev = prev_n; m_active = act_n;
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    model_reset();
  endtask

  task automatic to_next_step();
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (m_step) break;
    end
    cycle();
  endtask

  task automatic test_reset();
    enable = 1'b1; duty = 2'd3; mode = 2'd0;
    do_reset();
    n_checks++;
    if (led !== 4'b0000 || pos !== 2'd0 || step !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state led=%b pos=%0d step=%b want 0000/0/0", led, pos, step);
    end
    for (int c = 1; c <= 6; c++) begin
      cycle();
      n_checks++;
      if (step !== (c == 4)) begin
        n_fail++;
        $display("FAIL reset_step c=%0d step=%b want %b", c, step, c == 4);
      end
      n_checks++;
      if (led !== ((c == 6) ? 4'b0001 : 4'b0000)) begin
        n_fail++;
        $display("FAIL reset_led c=%0d led=%b want %b", c, led,
                 (c == 6) ? 4'b0001 : 4'b0000);
      end
      if (c == 4) begin
        n_checks++;
        if (pos !== 2'd0) begin
          n_fail++;
          $display("FAIL reset_pos c=4 pos=%0d want 0", pos);
        end
      end
    end
  endtask

  task automatic test_chase();
    int exp_up[4] = '{1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      to_next_step();
      n_checks++;
      if (pos !== 2'(exp_up[i]) || int'(pos) != m_pos) begin
        n_fail++;
        $display("FAIL chase_up i=%0d pos=%0d want %0d", i, pos, exp_up[i]);
      end
    end
    mode = 2'd1;
    to_next_step();
    n_checks++;
    if (pos !== 2'd3) begin
      n_fail++;
      $display("FAIL chase_down_wrap pos=%0d want 3", pos);
    end
  endtask

  task automatic test_bounce();
    int exp_b[8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    mode = 2'd2;
    do_reset();
    to_next_step();
    for (int i = 0; i < 8; i++) begin
      to_next_step();
      n_checks++;
      if (pos !== 2'(exp_b[i]) || int'(pos) != m_pos) begin
        n_fail++;
        $display("FAIL bounce i=%0d pos=%0d want %0d", i, pos, exp_b[i]);
      end
    end
  endtask

  task automatic test_fill();
    logic [N-1:0] exp_p[5] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0001};
    logic [N-1:0] acc;
    int cnt[N];
    mode = 2'd3; duty = 2'd3;
    do_reset();
    to_next_step();
    for (int p = 0; p < 5; p++) begin
      acc = '0;
      for (int i = 0; i < N; i++) cnt[i] = 0;
      for (int c = 0; c < 4; c++) begin
        cycle();
        acc |= led;
        for (int i = 0; i < N; i++) cnt[i] += int'(led[i]);
        n_checks++;
        if (led !== m_led) begin
          n_fail++;
          $display("FAIL fill_led p=%0d c=%0d led=%b want %b", p, c, led, m_led);
        end
      end
      n_checks++;
      if (acc !== exp_p[p]) begin
        n_fail++;
        $display("FAIL fill_pattern p=%0d got=%b want %b", p, acc, exp_p[p]);
      end
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (cnt[i] != (exp_p[p][i] ? 3 : 0)) begin
          n_fail++;
          $display("FAIL fill_duty p=%0d bit=%0d on=%0d want %0d", p, i,
                   cnt[i], exp_p[p][i] ? 3 : 0);
        end
      end
    end
  endtask

  task automatic test_freeze();
    int held_pos;
    int got;
    cycle();
    held_pos = m_pos;
    enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      n_checks++;
      if (step !== 1'b0 || int'(pos) != held_pos || led !== m_led) begin
        n_fail++;
        $display("FAIL freeze c=%0d step=%b pos=%0d led=%b want 0/%0d/%b",
                 c, step, pos, led, held_pos, m_led);
      end
    end
    enable = 1'b1;
    got = 0;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (step === 1'b1) begin got = k; break; end
    end
    n_checks++;
    if (got != 2) begin
      n_fail++;
      $display("FAIL freeze_resume step_after=%0d want 2", got);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (m_led != '0 && m_pos != 0) break;
    end
    n_checks++;
    if (led !== m_led || led === '0) begin
      n_fail++;
      $display("FAIL async_pre led=%b want %b nonzero", led, m_led);
    end
    nrst = 1'b0;
    #1;
    n_checks++;
    if (led !== 4'b0000 || pos !== 2'd0 || step !== 1'b0) begin
      n_fail++;
      $display("FAIL async_clear led=%b pos=%0d step=%b want 0000/0/0", led, pos, step);
    end
    #2;
    nrst = 1'b1;
    model_reset();
    for (int c = 1; c <= 4; c++) begin
      cycle();
      n_checks++;
      if (step !== (c == 4) || pos !== 2'd0 || led !== 4'b0000) begin
        n_fail++;
        $display("FAIL async_restart c=%0d step=%b pos=%0d led=%b", c, step, pos, led);
      end
    end
  endtask

  task automatic test_random();
    logic [B-1:0] prev_duty;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(7) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(5) == 0) duty = B'($urandom_range(3));
      enable = m_step ? 1'b1 : ($urandom_range(4) != 0);
      prev_duty = duty;
      cycle();
      n_checks++;
      if (led !== m_led || int'(pos) != m_pos || step !== m_step) begin
        n_fail++;
        $display("FAIL random c=%0d led=%b pos=%0d step=%b want %b/%0d/%b",
                 c, led, pos, step, m_led, m_pos, m_step);
      end
      n_checks++;
      if (int'(pos) > N - 1 || (prev_duty == '0 && led !== '0)) begin
        n_fail++;
        $display("FAIL random_bounds c=%0d pos=%0d led=%b duty=%0d", c, pos, led, prev_duty);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_chase();
    test_bounce();
    test_fill();
    test_freeze();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
